// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential floating-point divider.
package fp_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StNorm,
    StDone
  } fp_div_state_e;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  // Returned right-aligned in 64 bits; callers cast to their word width.
  function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, overflow/underflow clamp and IEEE field packing.
module fp_round_pack
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   sign,
  input  logic [EXP_W+1:0]       exp_in,
  input  logic [MAN_W-1:0]       frac,
  input  logic                   guard,
  input  logic                   sticky,
  output logic [EXP_W+MAN_W:0]   res,
  output fp_flags_t              flags
);

  logic             round_up;
  logic [MAN_W:0]   sum;
  logic [EXP_W+1:0] exp_r;
  logic             ovf;
  logic             unf;

  always_comb begin
    round_up = guard & (sticky | frac[0]);
    sum      = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the fraction means the mantissa became 2.0: bump the exponent.
    exp_r    = exp_in + {{(EXP_W+1){1'b0}}, sum[MAN_W]};
    ovf      = !exp_r[EXP_W+1] && (exp_r[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
    unf      = exp_r[EXP_W+1] || (exp_r == '0);

    flags         = '0;
    flags.inexact = guard | sticky;
    res           = {sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
    if (ovf) begin
      res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
    end else if (unf) begin
      res             = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-style divider: restoring radix-2 mantissa divide, one bit per cycle.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] num1,
  input  logic [EXP_W+MAN_W:0] num2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] S,
  output logic [4:0]           flags
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned CntW = $clog2(MAN_W + 3);
  localparam logic [EXP_W+1:0] Bias = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0] QNaN = W'(canon_nan(EXP_W, MAN_W));

  fp_div_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W+2:0] quot_q, quot_d;
  logic [MAN_W:0]   div_q, div_d;
  logic [EXP_W+1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     s_q, s_d;
  fp_flags_t        flags_q, flags_d;

  logic             s1, s2;
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic             z1, z2, inf1, inf2, nan1, nan2, norm1, norm2;
  logic             sign_in, special;
  logic [W-1:0]     sp_res;
  fp_flags_t        sp_flags;
  logic [EXP_W+1:0] exp_init;

  assign {s1, e1, f1} = num1;
  assign {s2, e2, f2} = num2;

  // Subnormals are classified as zero.
  assign z1    = (e1 == '0);
  assign z2    = (e2 == '0);
  assign inf1  = (&e1) && (f1 == '0);
  assign inf2  = (&e2) && (f2 == '0);
  assign nan1  = (&e1) && (|f1);
  assign nan2  = (&e2) && (|f2);
  assign norm1 = !z1 && !(&e1);
  assign norm2 = !z2 && !(&e2);

  assign sign_in  = s1 ^ s2;
  assign special  = !(norm1 && norm2);
  assign exp_init = {2'b00, e1} - {2'b00, e2} + Bias;

  always_comb begin
    sp_res   = '0;
    sp_flags = '0;
    if (nan1 || nan2) begin
      sp_res = QNaN;
    end else if ((z1 && z2) || (inf1 && inf2)) begin
      sp_res           = QNaN;
      sp_flags.invalid = 1'b1;
    end else if (z2 && norm1) begin
      sp_res               = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_flags.div_by_zero = 1'b1;
    end else if (inf1) begin
      sp_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      sp_res = {sign_in, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  // One restoring step: subtract the divisor when it fits, then shift.
  logic [MAN_W+1:0] rem_step;
  logic             q_bit;
  always_comb begin
    q_bit    = (rem_q >= {1'b0, div_q});
    rem_step = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
  end

  logic             q_msb;
  logic [MAN_W-1:0] frac_n;
  logic             guard_n, sticky_n;
  logic [EXP_W+1:0] exp_n;
  logic [W-1:0]     rp_res;
  fp_flags_t        rp_flags;

  always_comb begin
    q_msb    = quot_q[MAN_W+2];
    frac_n   = q_msb ? quot_q[MAN_W+1:2] : quot_q[MAN_W:1];
    guard_n  = q_msb ? quot_q[1] : quot_q[0];
    sticky_n = (q_msb & quot_q[0]) | (rem_q != '0);
    exp_n    = q_msb ? exp_q : exp_q - (EXP_W+2)'(1);
  end

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_pack (
    .sign  (sign_q),
    .exp_in(exp_n),
    .frac  (frac_n),
    .guard (guard_n),
    .sticky(sticky_n),
    .res   (rp_res),
    .flags (rp_flags)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    div_d   = div_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    s_d     = s_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = sign_in;
          exp_d  = exp_init;
          rem_d  = {2'b01, f1};
          div_d  = {1'b1, f2};
          quot_d = '0;
          cnt_d  = CntW'(MAN_W + 2);
          if (special) begin
            s_d     = sp_res;
            flags_d = sp_flags;
            state_d = StDone;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d  = rem_step << 1;
        quot_d = {quot_q[MAN_W+1:0], q_bit};
        if (cnt_q == '0) begin
          state_d = StNorm;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StNorm: begin
        s_d     = rp_res;
        flags_d = rp_flags;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      div_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      s_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      s_q     <= s_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign S         = s_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq with hand-computed single-precision results.
module tb_fp_div_seq;

  localparam logic [4:0] FNone = 5'b00000;
  localparam logic [4:0] FInv  = 5'b10000;
  localparam logic [4:0] FDz   = 5'b01000;
  localparam logic [4:0] FOvf  = 5'b00101;
  localparam logic [4:0] FUnf  = 5'b00011;
  localparam logic [4:0] FInx  = 5'b00001;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] S;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_div_seq #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num1     (num1),
    .num2     (num2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .flags    (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_s, input logic [4:0] exp_f, input int exp_lat);
    int lat;
    @(negedge clk);
    num1      = a;
    num2      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_S"}, S, exp_s);
    check({tag, "_flags"}, {27'b0, flags}, {27'b0, exp_f});
    @(posedge clk);
    #1;
    check({tag, "_released"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_S", S, 32'h0);
    check("rst_flags", {27'b0, flags}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, FNone, 27);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, FInx, 27);
    run_op("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, FNone, 27);
    run_op("equal", 32'h3FC00000, 32'h3FC00000, 32'h3F800000, FNone, 27);
    run_op("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, FDz, 0);
    run_op("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, FInv, 0);
    run_op("inf_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, FInv, 0);
    run_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, FNone, 0);
    run_op("neg_inf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, FNone, 0);
    run_op("neg_zero_fin", 32'h80000000, 32'h40A00000, 32'h80000000, FNone, 0);
    run_op("fin_inf", 32'h40A00000, 32'hFF800000, 32'h80000000, FNone, 0);
    run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, FOvf, 27);
    run_op("underflow", 32'h00800000, 32'h4B000000, 32'h00000000, FUnf, 27);

    // Backpressure: result must hold while the second pair waits on in_valid.
    @(negedge clk);
    num1      = 32'h40C00000;
    num2      = 32'h40000000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    num1 = 32'h3F800000;
    num2 = 32'h40400000;
    wait_result(lat);
    check("bp_latency", lat, 27);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_S", S, 32'h40400000);
      check("bp_flags", {27'b0, flags}, 32'h0);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_taken", {31'b0, in_ready}, 32'd0);
    wait_result(lat);
    check("bp2_latency", lat, 27);
    check("bp2_S", S, 32'h3EAAAAAB);
    check("bp2_flags", {27'b0, flags}, {27'b0, FInx});
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the divide.
    @(negedge clk);
    num1     = 32'h40C00000;
    num2     = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_S", S, 32'h0);
    check("arst_flags", {27'b0, flags}, 32'h0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    run_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, FNone, 27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port num1  input  W  dividend.
REQ-008 SHALL have port num2  input  W  divisor.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port S  output  W  quotient num1/num2.
REQ-012 SHALL have port flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Function
REQ-013 SHALL accept operands on a rising edge with in_valid && in_ready and register them; in_ready SHALL be high only in state IDLE.
REQ-014 SHALL implement FSM IDLE -> (special case ? DONE : DIV) -> NORM -> DONE -> IDLE, leaving DONE on out_valid && out_ready.
REQ-015 SHALL, in DIV, run a restoring radix-2 mantissa divide on {1,frac}, one quotient bit per cycle, for MAN_W+3 cycles, driven by a down-counter.
REQ-016 SHALL, in NORM (one cycle), normalise: if quotient MSB set, use bits [MAN_W+2:2], guard = bit1, sticky = bit0 | (remainder != 0); else use bits [MAN_W+1:1], guard = bit0, sticky = (remainder != 0), and subtract 1 from the exponent.
REQ-017 SHALL compute biased exponent as e1 - e2 + (2^(EXP_W-1)-1) in EXP_W+2-bit signed arithmetic.
REQ-018 SHALL round to nearest, ties to even; a mantissa carry-out SHALL increment the exponent.
REQ-019 SHALL set inexact when guard|sticky is 1.
REQ-020 SHALL, when the rounded exponent >= 2^EXP_W-1, output signed infinity with overflow=1 and inexact=1.
REQ-021 SHALL, when the rounded exponent <= 0, output signed zero with underflow=1 and inexact=1 (flush-to-zero).
REQ-022 SHALL treat subnormal inputs as signed zero.
REQ-023 SHALL handle special cases in one cycle (out_valid after the first edge after accept), skipping DIV/NORM:
- either NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB only), no flag;
- 0/0 or inf/inf -> qNaN, invalid=1;
- finite nonzero/0 -> signed inf, div_by_zero=1;
- inf/finite -> signed inf; 0/nonzero or finite/inf -> signed zero; no flags.
REQ-024 SHALL compute sign = sign1 ^ sign2 for every non-NaN result.
REQ-025 SHALL assert out_valid exactly MAN_W+4 edges after the accepting edge for normal operands (27 for defaults).
REQ-026 SHALL hold S and flags stable while out_valid && !out_ready, and SHALL ignore in_valid until back in IDLE.
REQ-027 SHALL permit in_valid to be accepted on the edge after the result handshake (no bubble beyond the IDLE cycle).

Reset
REQ-028 SHALL, on rstn low at any time including mid-DIV, asynchronously force state IDLE, out_valid=0, S=0, flags=0, counter=0, and discard the in-flight operation.
REQ-029 SHALL drive in_ready=1 from the first edge after rstn deasserts.

Structure
REQ-030 SHALL place the FSM state enum, flags struct, and a canonical-NaN constant function of EXP_W/MAN_W in shared package fp_div_pkg.
REQ-031 SHALL implement rounding, overflow/underflow clamp and field packing in combinational sub-module fp_round_pack, instantiated once.

Verification
REQ-032 Bench SHALL cover 0x40C00000/0x40000000 -> S=0x40400000, flags=0, out_valid 27 edges after accept.
REQ-033 Bench SHALL cover 0x3F800000/0x40400000 -> S=0x3EAAAAAB, inexact=1 only.
REQ-034 Bench SHALL cover 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1, 1-cycle latency; 0/0 -> 0x7FC00000, invalid=1.
REQ-035 Bench SHALL cover 0x7F000000/0x3E800000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000/0x4B000000 -> 0x00000000, underflow=1, inexact=1.
REQ-036 Bench SHALL cover out_ready held low 5 cycles after out_valid -> S/flags stable, in_ready=0, second operand pair not taken until handshake.
REQ-037 Bench SHALL cover rstn pulsed low at DIV cycle 10 -> out_valid=0, S=0 immediately; next 6.0/2.0 yields 0x40400000.
